// File: rtl/regs_param.sv
`default_nettype none
// ============================================================================
// Module   : regs_param
// Brief    : Two-read/one-write register file with a DEPTH-cycle clear sweep,
//            optional hard-wired zero entry and optional registered reads.
// Revision : 1.0 - initial release
// ============================================================================
module regs_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int READ_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg1_raddr_i,
    input  logic [ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0] reg1_rdata_o,
    output logic [DATA_W-1:0] reg2_rdata_o,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic [DATA_W-1:0] reg_wdata_i,
    input  logic              reg_wen,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              wr_drop_o
);

    localparam int                c_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wr_drop;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_busy;
    logic              w_user_we;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_busy    = (r_state == CLEAR);
    assign busy_o    = w_busy;
    assign wr_drop_o = r_wr_drop;

    // Entry 0 is never written when it is hard-wired to zero.
    assign w_user_we = (r_state == READY) && reg_wen &&
                       !((ZERO_REG != 0) && (reg_waddr_i == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_ptr     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_busy && reg_wen;
            case (r_state)
                CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == c_LAST) begin
                        r_state <= READY;
                    end
                end
                READY: begin
                    if (clear_i) begin
                        r_state <= CLEAR;
                        r_ptr   <= '0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // Asynchronous reset of the array guarantees a write coincident with rst never lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_busy) begin
            r_mem[r_ptr] <= '0;
        end else if (w_user_we) begin
            r_mem[reg_waddr_i] <= reg_wdata_i;
        end
    end

    always_comb begin
        w_rd1 = r_mem[reg1_raddr_i];
        if (w_busy) begin
            w_rd1 = '0;
        end else if ((ZERO_REG != 0) && (reg1_raddr_i == '0)) begin
            w_rd1 = '0;
        end else if (reg_wen && (reg_waddr_i == reg1_raddr_i)) begin
            w_rd1 = reg_wdata_i;
        end
    end

    always_comb begin
        w_rd2 = r_mem[reg2_raddr_i];
        if (w_busy) begin
            w_rd2 = '0;
        end else if ((ZERO_REG != 0) && (reg2_raddr_i == '0)) begin
            w_rd2 = '0;
        end else if (reg_wen && (reg_waddr_i == reg2_raddr_i)) begin
            w_rd2 = reg_wdata_i;
        end
    end

    generate
        if (READ_REG != 0) begin : g_reg_read
            logic [DATA_W-1:0] r_rd1;
            logic [DATA_W-1:0] r_rd2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd1 <= '0;
                    r_rd2 <= '0;
                end else begin
                    r_rd1 <= w_rd1;
                    r_rd2 <= w_rd2;
                end
            end

            assign reg1_rdata_o = r_rd1;
            assign reg2_rdata_o = r_rd2;
        end else begin : g_comb_read
            assign reg1_rdata_o = w_rd1;
            assign reg2_rdata_o = w_rd2;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/regs_param.md
REGS_PARAM -- requirements
Module: regs_param

Interface
REQ-001 Parameter DATA_W, default 32, sets the register width in bits.
REQ-002 Parameter ADDR_W, default 5, sets the address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1; when 1, entry 0 always reads as zero and ignores writes.
REQ-004 Parameter READ_REG, default 0; 0 gives combinational read ports, 1 gives registered read ports with one-cycle latency.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port reg1_raddr_i, input, ADDR_W bits: read port 1 address.
REQ-008 Port reg2_raddr_i, input, ADDR_W bits: read port 2 address.
REQ-009 Port reg1_rdata_o, output, DATA_W bits: read port 1 data.
REQ-010 Port reg2_rdata_o, output, DATA_W bits: read port 2 data.
REQ-011 Port reg_waddr_i, input, ADDR_W bits: write address.
REQ-012 Port reg_wdata_i, input, DATA_W bits: write data.
REQ-013 Port reg_wen, input, 1 bit: write enable, sampled on the rising edge.
REQ-014 Port clear_i, input, 1 bit: synchronous request to zero the whole array.
REQ-015 Port busy_o, output, 1 bit: high while the clear sweep runs; writes are not accepted.
REQ-016 Port wr_drop_o, output, 1 bit: registered one-cycle pulse, asserted for each write rejected because busy_o was high.

Function
REQ-017 The FSM shall have exactly two states: CLEAR and READY.
REQ-018 In CLEAR, the FSM shall write zero to entry ptr each cycle and then increment ptr; ptr is ADDR_W bits wide.
REQ-019 In CLEAR with ptr == DEPTH-1, the FSM shall write that last entry and move to READY on the same edge.
REQ-020 A full sweep shall therefore take exactly DEPTH cycles, with busy_o high for those DEPTH cycles.
REQ-021 If clear_i is high in READY, the FSM shall move to CLEAR with ptr = 0 on the next edge.
REQ-022 clear_i shall be ignored while in CLEAR; the sweep does not restart.
REQ-023 busy_o shall equal (state == CLEAR).
REQ-024 In READY, a write with reg_wen = 1 shall store reg_wdata_i into entry reg_waddr_i on the rising edge.
- Exception: if ZERO_REG = 1 and reg_waddr_i = 0, the write is discarded and wr_drop_o is not asserted.
REQ-025 In CLEAR, a write with reg_wen = 1 shall be discarded, and wr_drop_o shall be 1 in the following cycle.
REQ-026 Read value per port, in priority order:
- 0 when busy_o = 1;
- else 0 when ZERO_REG = 1 and the port address is 0;
- else reg_wdata_i when reg_wen = 1 and reg_waddr_i equals the port address (same-cycle write bypass);
- else the stored entry.
REQ-027 With READ_REG = 0, each rdata output shall be the REQ-026 value, combinational in the same cycle.
REQ-028 With READ_REG = 1, each rdata output shall register the REQ-026 value on the rising edge, so data appears one cycle after the address.
REQ-029 Both read ports shall be fully independent; identical addresses on both ports return identical data.
REQ-030 clear_i arriving in READY in the same cycle as a write shall still commit that write; the sweep that follows then zeroes it.

Reset
REQ-031 Asserting rst shall immediately force state = CLEAR, ptr = 0, wr_drop_o = 0, and the registered rdata outputs (READ_REG = 1) to 0.
REQ-032 After rst deasserts, a full DEPTH-cycle sweep shall run before the first write is accepted.
REQ-033 rst asserted mid-sweep or mid-write shall abort the operation and restart from REQ-031; no partial write shall commit on that edge.

Verification
REQ-034 Reset release: busy_o is 1 for exactly 32 cycles (defaults), then 0; all 32 entries read as 0.
REQ-035 Bypass, READ_REG = 0: write 0xDEADBEEF to reg 5 with reg1_raddr_i = 5 -> reg1_rdata_o = 0xDEADBEEF in the same cycle, and it still reads so the next cycle.
REQ-036 Zero register: write 0x12345678 to reg 0 -> both ports read 0 at address 0 and wr_drop_o stays 0.
REQ-037 Busy write: after clear_i, write 0xA5A5A5A5 to reg 3 in the 2nd sweep cycle -> wr_drop_o = 1 for one cycle and reg 3 reads 0 once READY.
REQ-038 Registered reads, READ_REG = 1: with reg 7 = 0x0000FFFF, present address 7 -> reg2_rdata_o = 0x0000FFFF one cycle later; outputs read 0 during reset.
REQ-039 Reset mid-sweep: assert rst at sweep cycle 10 -> busy_o stays 1, and a new full 32-cycle sweep follows release.
